// File: rtl/issue_stall_ctrl.sv
// issue_stall_ctrl: ID-side pipeline sequencer for the dual-issue core.
// Decides dual/single/no issue, builds the {MEM,EX,ID/EX,IF/ID} stall vector,
// inserts one bubble on load-use hazards and guards data-memory waits with a
// timeout watchdog.
module issue_stall_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             id_valid1,
  input  logic             id_valid2,
  input  logic [1:0]       id1_re,
  input  logic [9:0]       id1_raddr,
  input  logic             id1_we,
  input  logic [4:0]       id1_waddr,
  input  logic             id1_is_mem,
  input  logic [1:0]       id2_re,
  input  logic [9:0]       id2_raddr,
  input  logic             id2_is_mem,
  input  logic             id2_is_branch,
  input  logic             ex_we_i1,
  input  logic             ex_we_i2,
  input  logic [4:0]       ex_waddr_i1,
  input  logic [4:0]       ex_waddr_i2,
  input  logic             ex_is_load_i1,
  input  logic             ex_is_load_i2,
  input  logic             mem_req,
  input  logic             mem_ack,
  output logic [3:0]       stall,
  output logic             dual_issue,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int TMR_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

  state_t           state_r;
  state_t           next_state_s;
  logic [TMR_W-1:0] timer_r;
  logic [TMR_W-1:0] next_timer_s;
  logic             timeout_set_s;
  logic [3:0]       stall_s;
  logic             dual_s;
  logic             lu1_s;
  logic             lu2_s;
  logic             pair_ok_s;

  // True when an enabled, non-zero source of {src2,src1} matches a writer.
  function automatic logic src_hit(input logic [1:0] re, input logic [9:0] raddr,
                                   input logic wr, input logic [4:0] waddr);
    logic h;
    h = 1'b0;
    if (wr && re[0] && (raddr[4:0] != 5'd0) && (raddr[4:0] == waddr)) begin
      h = 1'b1;
    end else begin
      h = h;
    end
    if (wr && re[1] && (raddr[9:5] != 5'd0) && (raddr[9:5] == waddr)) begin
      h = 1'b1;
    end else begin
      h = h;
    end
    return h;
  endfunction

  // Hazard detection and static pairing rules for the ID pair.
  always_comb begin
    lu1_s = id_valid1 &&
            (src_hit(id1_re, id1_raddr, ex_is_load_i1 && ex_we_i1, ex_waddr_i1) ||
             src_hit(id1_re, id1_raddr, ex_is_load_i2 && ex_we_i2, ex_waddr_i2));
    lu2_s = id_valid2 &&
            (src_hit(id2_re, id2_raddr, ex_is_load_i1 && ex_we_i1, ex_waddr_i1) ||
             src_hit(id2_re, id2_raddr, ex_is_load_i2 && ex_we_i2, ex_waddr_i2));
    pair_ok_s = id_valid1 && id_valid2 &&
                !src_hit(id2_re, id2_raddr, id1_we, id1_waddr) &&
                !(id1_is_mem && id2_is_mem) &&
                !id2_is_branch && !lu2_s;
  end

  // Next-state, timer update and stall vector per FSM state.
  always_comb begin
    next_state_s  = state_r;
    next_timer_s  = timer_r;
    timeout_set_s = 1'b0;
    stall_s       = 4'b0000;
    case (state_r)
      ST_RUN: begin
        if (flush) begin
          stall_s = 4'b0000;
        end else if (mem_req && !mem_ack) begin
          stall_s      = 4'b1111;
          next_state_s = ST_WAIT;
          next_timer_s = TMR_W'(1);
        end else if (lu1_s) begin
          // Single bubble: the load moves to MEM and forwards next cycle.
          stall_s = 4'b0001;
        end else begin
          stall_s = 4'b0000;
        end
      end
      ST_WAIT: begin
        if (flush || mem_ack) begin
          stall_s      = 4'b0000;
          next_state_s = ST_RUN;
          next_timer_s = TMR_W'(0);
        end else if (timer_r >= TMR_W'(MEM_TIMEOUT)) begin
          stall_s       = 4'b1111;
          timeout_set_s = 1'b1;
          next_state_s  = ST_ERR;
          next_timer_s  = TMR_W'(0);
        end else begin
          stall_s      = 4'b1111;
          next_timer_s = timer_r + TMR_W'(1);
        end
      end
      ST_ERR: begin
        if (flush) begin
          stall_s      = 4'b0000;
          next_state_s = ST_RUN;
          next_timer_s = TMR_W'(0);
        end else begin
          stall_s = 4'b1111;
        end
      end
      default: begin
        stall_s      = 4'b0000;
        next_state_s = ST_RUN;
        next_timer_s = TMR_W'(0);
      end
    endcase
    dual_s = !flush && (stall_s == 4'b0000) && pair_ok_s;
  end

  // Outputs are forced quiet while reset is held.
  always_comb begin
    if (rst) begin
      stall      = 4'b0000;
      dual_issue = 1'b0;
    end else begin
      stall      = stall_s;
      dual_issue = dual_s;
    end
  end

  // FSM state, wait timer, sticky timeout flag and saturating stall counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_RUN;
      timer_r      <= TMR_W'(0);
      mem_timeout  <= 1'b0;
      stall_cycles <= CNT_W'(0);
    end else begin
      state_r <= next_state_s;
      timer_r <= next_timer_s;
      if (timeout_set_s) begin
        mem_timeout <= 1'b1;
      end
      if (stall_s[0] && (stall_cycles != {CNT_W{1'b1}})) begin
        stall_cycles <= stall_cycles + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_issue_stall_ctrl.sv
// Directed testbench for issue_stall_ctrl (MEM_TIMEOUT=4, CNT_W=3).
module tb_issue_stall_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       id_valid1, id_valid2;
  logic [1:0] id1_re, id2_re;
  logic [9:0] id1_raddr, id2_raddr;
  logic       id1_we;
  logic [4:0] id1_waddr;
  logic       id1_is_mem, id2_is_mem, id2_is_branch;
  logic       ex_we_i1, ex_we_i2;
  logic [4:0] ex_waddr_i1, ex_waddr_i2;
  logic       ex_is_load_i1, ex_is_load_i2;
  logic       mem_req, mem_ack;
  logic [3:0] stall;
  logic       dual_issue;
  logic       mem_timeout;
  logic [2:0] stall_cycles;

  int tests = 0;
  int fails = 0;

  issue_stall_ctrl #(.MEM_TIMEOUT(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .id_valid1(id_valid1), .id_valid2(id_valid2),
    .id1_re(id1_re), .id1_raddr(id1_raddr), .id1_we(id1_we), .id1_waddr(id1_waddr),
    .id1_is_mem(id1_is_mem),
    .id2_re(id2_re), .id2_raddr(id2_raddr), .id2_is_mem(id2_is_mem),
    .id2_is_branch(id2_is_branch),
    .ex_we_i1(ex_we_i1), .ex_we_i2(ex_we_i2),
    .ex_waddr_i1(ex_waddr_i1), .ex_waddr_i2(ex_waddr_i2),
    .ex_is_load_i1(ex_is_load_i1), .ex_is_load_i2(ex_is_load_i2),
    .mem_req(mem_req), .mem_ack(mem_ack),
    .stall(stall), .dual_issue(dual_issue), .mem_timeout(mem_timeout),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    flush = 1'b0; id_valid1 = 1'b0; id_valid2 = 1'b0;
    id1_re = 2'b00; id1_raddr = 10'd0; id1_we = 1'b0; id1_waddr = 5'd0; id1_is_mem = 1'b0;
    id2_re = 2'b00; id2_raddr = 10'd0; id2_is_mem = 1'b0; id2_is_branch = 1'b0;
    ex_we_i1 = 1'b0; ex_we_i2 = 1'b0; ex_waddr_i1 = 5'd0; ex_waddr_i2 = 5'd0;
    ex_is_load_i1 = 1'b0; ex_is_load_i2 = 1'b0; mem_req = 1'b0; mem_ack = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    // hazard and memory request while in reset must not leak to outputs
    mem_req = 1'b1; id_valid1 = 1'b1; id1_re = 2'b01; id1_raddr = {5'd0, 5'd5};
    ex_is_load_i1 = 1'b1; ex_we_i1 = 1'b1; ex_waddr_i1 = 5'd5;
    #1;
    tests++; if (stall !== 4'b0000) begin fails++; $display("FAIL rst_stall: got %b exp 0000", stall); end
    tests++; if (dual_issue !== 1'b0) begin fails++; $display("FAIL rst_dual: got %b exp 0", dual_issue); end
    step();
    tests++; if (mem_timeout !== 1'b0) begin fails++; $display("FAIL rst_timeout: got %b exp 0", mem_timeout); end
    tests++; if (stall_cycles !== 3'd0) begin fails++; $display("FAIL rst_cnt: got %0d exp 0", stall_cycles); end
    do_reset();
  endtask

  task automatic test_load_use();
    do_reset();
    ex_is_load_i1 = 1'b1; ex_we_i1 = 1'b1; ex_waddr_i1 = 5'd5;
    id_valid1 = 1'b1; id1_re = 2'b01; id1_raddr = {5'd0, 5'd5};
    id_valid2 = 1'b1;
    #1;
    tests++; if (stall !== 4'b0001) begin fails++; $display("FAIL lu_stall: got %b exp 0001", stall); end
    tests++; if (dual_issue !== 1'b0) begin fails++; $display("FAIL lu_dual: got %b exp 0", dual_issue); end
    step();
    // load advanced to MEM, EX now holds the bubble
    ex_is_load_i1 = 1'b0; ex_we_i1 = 1'b0; ex_waddr_i1 = 5'd0;
    #1;
    tests++; if (stall !== 4'b0000) begin fails++; $display("FAIL lu_release: got %b exp 0000", stall); end
    tests++; if (stall_cycles !== 3'd1) begin fails++; $display("FAIL lu_cnt: got %0d exp 1", stall_cycles); end
    // register 0 never hazards
    ex_is_load_i1 = 1'b1; ex_we_i1 = 1'b1; ex_waddr_i1 = 5'd0; id1_raddr = 10'd0;
    #1;
    tests++; if (stall !== 4'b0000) begin fails++; $display("FAIL lu_r0: got %b exp 0000", stall); end
    // hazard via EX slot 2 on src2
    ex_is_load_i1 = 1'b0; ex_is_load_i2 = 1'b1; ex_we_i2 = 1'b1; ex_waddr_i2 = 5'd9;
    id1_re = 2'b10; id1_raddr = {5'd9, 5'd0};
    #1;
    tests++; if (stall !== 4'b0001) begin fails++; $display("FAIL lu_ex2: got %b exp 0001", stall); end
    // only slot 2 hazards: slot 1 issues single, no stall
    id1_re = 2'b01; id1_raddr = {5'd0, 5'd3};
    id2_re = 2'b01; id2_raddr = {5'd0, 5'd9};
    #1;
    tests++; if (stall !== 4'b0000) begin fails++; $display("FAIL lu2_stall: got %b exp 0000", stall); end
    tests++; if (dual_issue !== 1'b0) begin fails++; $display("FAIL lu2_dual: got %b exp 0", dual_issue); end
    step();
  endtask

  task automatic test_dual_issue();
    do_reset();
    id_valid1 = 1'b1; id_valid2 = 1'b1;
    id1_we = 1'b1; id1_waddr = 5'd3; id1_re = 2'b01; id1_raddr = {5'd0, 5'd1};
    id2_re = 2'b11; id2_raddr = {5'd2, 5'd4};
    #1;
    tests++; if (dual_issue !== 1'b1) begin fails++; $display("FAIL dual_indep: got %b exp 1", dual_issue); end
    id1_waddr = 5'd7; id2_raddr = {5'd7, 5'd4};
    #1;
    tests++; if (dual_issue !== 1'b0) begin fails++; $display("FAIL dual_raw: got %b exp 0", dual_issue); end
    tests++; if (stall !== 4'b0000) begin fails++; $display("FAIL dual_raw_stall: got %b exp 0000", stall); end
    id1_waddr = 5'd3; id2_raddr = {5'd2, 5'd4}; id1_is_mem = 1'b1; id2_is_mem = 1'b1;
    #1;
    tests++; if (dual_issue !== 1'b0) begin fails++; $display("FAIL dual_mem: got %b exp 0", dual_issue); end
    id2_is_mem = 1'b0;
    #1;
    tests++; if (dual_issue !== 1'b1) begin fails++; $display("FAIL dual_one_mem: got %b exp 1", dual_issue); end
    id2_is_branch = 1'b1;
    #1;
    tests++; if (dual_issue !== 1'b0) begin fails++; $display("FAIL dual_branch: got %b exp 0", dual_issue); end
    id2_is_branch = 1'b0; id_valid2 = 1'b0;
    #1;
    tests++; if (dual_issue !== 1'b0) begin fails++; $display("FAIL dual_v2: got %b exp 0", dual_issue); end
    // r0 match with slot 1 writing r0 is not a dependency
    id_valid2 = 1'b1; id1_waddr = 5'd0; id2_raddr = {5'd0, 5'd0};
    #1;
    tests++; if (dual_issue !== 1'b1) begin fails++; $display("FAIL dual_r0: got %b exp 1", dual_issue); end
    step();
  endtask

  task automatic test_mem_wait();
    do_reset();
    mem_req = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      #1;
      tests++; if (stall !== 4'b1111) begin fails++; $display("FAIL wait_c%0d: got %b exp 1111", c, stall); end
      step();
    end
    mem_ack = 1'b1;
    #1;
    tests++; if (stall !== 4'b0000) begin fails++; $display("FAIL wait_ack: got %b exp 0000", stall); end
    step();
    mem_req = 1'b0; mem_ack = 1'b0;
    #1;
    tests++; if (stall !== 4'b0000) begin fails++; $display("FAIL wait_after: got %b exp 0000", stall); end
    tests++; if (stall_cycles !== 3'd3) begin fails++; $display("FAIL wait_cnt: got %0d exp 3", stall_cycles); end
    mem_req = 1'b1; mem_ack = 1'b1;
    #1;
    tests++; if (stall !== 4'b0000) begin fails++; $display("FAIL zero_wait: got %b exp 0000", stall); end
    step();
    mem_req = 1'b0; mem_ack = 1'b1;
    #1;
    tests++; if (stall !== 4'b0000) begin fails++; $display("FAIL stray_ack: got %b exp 0000", stall); end
    step();
    mem_ack = 1'b0;
    #1;
    tests++; if (stall !== 4'b0000) begin fails++; $display("FAIL still_run: got %b exp 0000", stall); end
    tests++; if (stall_cycles !== 3'd3) begin fails++; $display("FAIL zero_wait_cnt: got %0d exp 3", stall_cycles); end
  endtask

  task automatic test_timeout();
    do_reset();
    mem_req = 1'b1;
    step();          // RUN -> WAIT
    step();          // WAIT cycle 1
    step();          // WAIT cycle 2
    step();          // WAIT cycle 3
    tests++; if (mem_timeout !== 1'b0) begin fails++; $display("FAIL to_early: got %b exp 0", mem_timeout); end
    step();          // WAIT cycle 4 -> ERR
    tests++; if (mem_timeout !== 1'b1) begin fails++; $display("FAIL to_set: got %b exp 1", mem_timeout); end
    mem_req = 1'b0; mem_ack = 1'b1;
    #1;
    tests++; if (stall !== 4'b1111) begin fails++; $display("FAIL err_stall: got %b exp 1111", stall); end
    step();
    mem_ack = 1'b0;
    #1;
    tests++; if (stall !== 4'b1111) begin fails++; $display("FAIL err_hold: got %b exp 1111", stall); end
    flush = 1'b1;
    #1;
    tests++; if (stall !== 4'b0000) begin fails++; $display("FAIL err_flush: got %b exp 0000", stall); end
    step();
    flush = 1'b0;
    #1;
    tests++; if (stall !== 4'b0000) begin fails++; $display("FAIL err_to_run: got %b exp 0000", stall); end
    tests++; if (mem_timeout !== 1'b1) begin fails++; $display("FAIL to_sticky: got %b exp 1", mem_timeout); end
  endtask

  task automatic test_flush();
    do_reset();
    flush = 1'b1; mem_req = 1'b1;
    ex_is_load_i1 = 1'b1; ex_we_i1 = 1'b1; ex_waddr_i1 = 5'd5;
    id_valid1 = 1'b1; id_valid2 = 1'b1; id1_re = 2'b01; id1_raddr = {5'd0, 5'd5};
    #1;
    tests++; if (stall !== 4'b0000) begin fails++; $display("FAIL fl_stall: got %b exp 0000", stall); end
    tests++; if (dual_issue !== 1'b0) begin fails++; $display("FAIL fl_dual: got %b exp 0", dual_issue); end
    step();
    clear_inputs();
    #1;
    tests++; if (stall !== 4'b0000) begin fails++; $display("FAIL fl_stay_run: got %b exp 0000", stall); end
    tests++; if (stall_cycles !== 3'd0) begin fails++; $display("FAIL fl_cnt: got %0d exp 0", stall_cycles); end
    mem_req = 1'b1;
    step();
    step();
    flush = 1'b1;
    #1;
    tests++; if (stall !== 4'b0000) begin fails++; $display("FAIL fl_wait: got %b exp 0000", stall); end
    step();
    flush = 1'b0; mem_req = 1'b0;
    #1;
    tests++; if (stall !== 4'b0000) begin fails++; $display("FAIL fl_wait_run: got %b exp 0000", stall); end
    tests++; if (stall_cycles !== 3'd2) begin fails++; $display("FAIL fl_wait_cnt: got %0d exp 2", stall_cycles); end
  endtask

  task automatic test_async_reset();
    do_reset();
    mem_req = 1'b1;
    step();
    step();          // in WAIT
    #3 rst = 1'b1;
    #1;
    tests++; if (stall !== 4'b0000) begin fails++; $display("FAIL ar_wait_stall: got %b exp 0000", stall); end
    tests++; if (stall_cycles !== 3'd0) begin fails++; $display("FAIL ar_wait_cnt: got %0d exp 0", stall_cycles); end
    rst = 1'b0;
    step();          // RUN with mem_req -> WAIT again
    for (int i = 0; i < 9; i++) step();
    tests++; if (stall_cycles !== 3'd7) begin fails++; $display("FAIL sat_cnt: got %0d exp 7", stall_cycles); end
    tests++; if (mem_timeout !== 1'b1) begin fails++; $display("FAIL sat_to: got %b exp 1", mem_timeout); end
    #3 rst = 1'b1;
    #1;
    tests++; if (stall !== 4'b0000) begin fails++; $display("FAIL ar_err_stall: got %b exp 0000", stall); end
    tests++; if (stall_cycles !== 3'd0) begin fails++; $display("FAIL ar_err_cnt: got %0d exp 0", stall_cycles); end
    tests++; if (mem_timeout !== 1'b0) begin fails++; $display("FAIL ar_err_to: got %b exp 0", mem_timeout); end
    mem_req = 1'b0;
    step();
    rst = 1'b0;
    #1;
    tests++; if (stall !== 4'b0000) begin fails++; $display("FAIL ar_run: got %b exp 0000", stall); end
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    test_reset();
    test_load_use();
    test_dual_issue();
    test_mem_wait();
    test_timeout();
    test_flush();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
